// File: rtl/lut_neuron_loader_pkg.sv
// Shared types and sizing helpers for the runtime-loadable neuron truth table.
package neuron_lut_pkg;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  localparam int DEF_IN_BITS   = 8;
  localparam int DEF_OUT_BITS  = 2;
  localparam int DEF_WORD_BITS = 16;

  function automatic int entries(input int in_bits);
    return 1 << in_bits;
  endfunction

  function automatic int per_word(input int word_bits, input int out_bits);
    return word_bits / out_bits;
  endfunction

  function automatic int nwords(input int in_bits, input int out_bits, input int word_bits);
    return entries(in_bits) / per_word(word_bits, out_bits);
  endfunction

  // Counter width that never collapses to zero bits when only one word is needed.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/lut_neuron_loader_if.sv
// Table-load stream plus lookup request/response bundle.
interface lut_neuron_loader_if import neuron_lut_pkg::*; #(
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS
) ();

  logic                 cfg_start;
  logic                 cfg_valid;
  logic [WORD_BITS-1:0] cfg_data;
  logic                 cfg_ready;
  logic                 cfg_done;
  logic                 in_valid;
  logic [IN_BITS-1:0]   in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_BITS-1:0]  out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    input  cfg_ready, cfg_done, in_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    output cfg_ready, cfg_done, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lut_neuron_loader_ram.sv
// Distributed truth-table RAM: one word-slot wide write, one entry registered read.
module lut_neuron_ram import neuron_lut_pkg::*; #(
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS,
  parameter int PER_WORD  = per_word(DEF_WORD_BITS, DEF_OUT_BITS),
  parameter int SLOT_BITS = clog2_min1(entries(DEF_IN_BITS) / per_word(DEF_WORD_BITS, DEF_OUT_BITS))
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [SLOT_BITS-1:0]         wr_slot,
  input  logic [PER_WORD*OUT_BITS-1:0] wr_data,
  input  logic                         rd_en,
  input  logic [IN_BITS-1:0]           rd_addr,
  output logic [OUT_BITS-1:0]          rd_data
);

  localparam int ENTRIES = entries(IN_BITS);

  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [ENTRIES];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < PER_WORD; k++) begin
        mem[IN_BITS'(int'(wr_slot) * PER_WORD + k)] <= wr_data[k*OUT_BITS +: OUT_BITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/lut_neuron_loader.sv
// Load FSM, word counter and handshakes around the programmable neuron table.
module lut_neuron_loader import neuron_lut_pkg::*; #(
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int OUT_BITS  = DEF_OUT_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS
) (
  input  logic                clk,
  input  logic                rst,
  lut_neuron_loader_if.slave  bus
);

  localparam int PER_WORD = per_word(WORD_BITS, OUT_BITS);
  localparam int NWORDS   = nwords(IN_BITS, OUT_BITS, WORD_BITS);
  localparam int CNT_BITS = clog2_min1(NWORDS);

  state_t              state;
  logic [CNT_BITS-1:0] count;
  logic                cfg_accept;
  logic                rd_accept;

  // A start pulse always wins, so neither side may handshake in that cycle.
  assign bus.cfg_ready = (state == LOAD) && !bus.cfg_start;
  assign bus.in_ready  = (state == RUN) && !bus.cfg_start;
  assign bus.cfg_done  = (state == RUN);
  assign cfg_accept    = bus.cfg_valid && bus.cfg_ready;
  assign rd_accept     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      count <= '0;
    end else if (bus.cfg_start) begin
      state <= LOAD;
      count <= '0;
    end else if (cfg_accept) begin
      count <= count + 1'b1;
      if (count == CNT_BITS'(NWORDS - 1)) begin
        state <= RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= rd_accept;
    end
  end

  lut_neuron_ram #(
    .IN_BITS   (IN_BITS),
    .OUT_BITS  (OUT_BITS),
    .PER_WORD  (PER_WORD),
    .SLOT_BITS (CNT_BITS)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cfg_accept),
    .wr_slot (count),
    .wr_data (bus.cfg_data),
    .rd_en   (rd_accept),
    .rd_addr (bus.in_data),
    .rd_data (bus.out_data)
  );

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Scoreboard bench: a table/word-count model predicts handshakes and lookup results.
module tb_lut_neuron_loader;

  localparam int IN_BITS   = 8;
  localparam int OUT_BITS  = 2;
  localparam int WORD_BITS = 16;
  localparam int PER_WORD  = WORD_BITS / OUT_BITS;
  localparam int NWORDS    = (1 << IN_BITS) / PER_WORD;
  localparam int M_EMPTY   = 0;
  localparam int M_LOAD    = 1;
  localparam int M_RUN     = 2;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  logic clk;
  logic rst;

  lut_neuron_loader_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .WORD_BITS(WORD_BITS)) bus ();

  lut_neuron_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .WORD_BITS(WORD_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   mode = M_EMPTY;
  int   mcnt = 0;
  int   hs_count = 0;
  int   mtable [1 << IN_BITS];
  int   last_out = 0;
  bit   mon_en = 0;
  exp_t exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock of stimulus; the model decides acceptance and the future lookup result.
  task automatic applyStimulus(input bit start, input bit cvalid, input logic [15:0] cdata,
                               input bit ivalid, input logic [7:0] idata);
    exp_t e;
    @(negedge clk);
    bus.cfg_start = start;
    bus.cfg_valid = cvalid;
    bus.cfg_data  = cdata;
    bus.in_valid  = ivalid;
    bus.in_data   = idata;
    #1;
    checkOutput("cfg_ready", int'(bus.cfg_ready), (mode == M_LOAD && !start) ? 1 : 0);
    checkOutput("cfg_done",  int'(bus.cfg_done),  (mode == M_RUN) ? 1 : 0);
    checkOutput("in_ready",  int'(bus.in_ready),  (mode == M_RUN && !start) ? 1 : 0);
    if (cvalid && bus.cfg_ready) hs_count++;
    if (ivalid && mode == M_RUN && !start) begin
      e.data = mtable[idata];
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    if (start) begin
      mode = M_LOAD;
      mcnt = 0;
    end else if (mode == M_LOAD && cvalid) begin
      for (int k = 0; k < PER_WORD; k++) begin
        mtable[mcnt * PER_WORD + k] = int'(cdata >> (OUT_BITS * k)) & ((1 << OUT_BITS) - 1);
      end
      mcnt++;
      if (mcnt == NWORDS) mode = M_RUN;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic loadTable(input logic [15:0] word);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    for (int i = 0; i < NWORDS; i++) applyStimulus(1'b0, 1'b1, word, 1'b0, 8'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("out_data", int'(bus.out_data), e.data);
          checkOutput("latency", cyc - e.cyc, 1);
        end
        last_out = int'(bus.out_data);
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc + 1 <= cyc) begin
          checkOutput("missing_out_valid", 0, 1);
          void'(exp_q.pop_front());
        end
        checkOutput("out_data_hold", int'(bus.out_data), last_out);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    for (int i = 0; i < (1 << IN_BITS); i++) mtable[i] = 0;

    // Reset then idle: nothing is served from an empty table.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_cfg_ready", int'(bus.cfg_ready), 0);
    checkOutput("rst_cfg_done",  int'(bus.cfg_done),  0);
    checkOutput("rst_in_ready",  int'(bus.in_ready),  0);
    checkOutput("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_out_data",  int'(bus.out_data),  0);
    @(negedge clk);
    rst = 1'b0;
    last_out = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'hE4E4, 1'b1, 8'h00);

    // Full load and a few spot lookups.
    hs_count = 0;
    loadTable(16'hE4E4);
    checkOutput("load_handshakes", hs_count, NWORDS);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 8'h07);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 8'hFE);
    idle(2);

    // Back-to-back sweep of every address.
    for (int a = 0; a < (1 << IN_BITS); a++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 8'(a));
    idle(2);

    // Restart mid-load; the word beside the second start must be dropped.
    hs_count = 0;
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b0, 8'h0);
    for (int i = 0; i < NWORDS; i++) applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0, 8'h0);
    checkOutput("restart_handshakes", hs_count, 10 + NWORDS);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 8'($urandom));
    idle(2);

    // Reload from RUN with a lookup in flight just before the start pulse.
    loadTable(16'hE4E4);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 8'h03);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 8'h03);
    for (int i = 0; i < NWORDS; i++) applyStimulus(1'b0, 1'b1, 16'h5555, 1'b1, 8'h03);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 8'h03);
    idle(2);

    // Asynchronous reset between edges partway through a load.
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'hA5A5, 1'b0, 8'h0);
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("arst_cfg_ready", int'(bus.cfg_ready), 0);
    checkOutput("arst_cfg_done",  int'(bus.cfg_done),  0);
    checkOutput("arst_in_ready",  int'(bus.in_ready),  0);
    checkOutput("arst_out_valid", int'(bus.out_valid), 0);
    checkOutput("arst_out_data",  int'(bus.out_data),  0);
    mode = M_EMPTY;
    mcnt = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    last_out = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'h1234, 1'b1, 8'h05);

    // Randomized traffic with occasional reloads.
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), 16'($urandom),
                    $urandom_range(0, 3) != 0, 8'($urandom));
    end
    idle(3);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
